// File: rtl/rpn_output_queue.sv
// rpn_output_queue: token store for the RPN output queue of a fixed-point
// expression evaluator. Tokens are appended at the tail and read back by
// random index with a fixed one-cycle registered read latency.
// Optional feature macro: OUTPUT_QUEUE_BOUNDS_CHECK_EN
//   defined   -> reads at index >= length return 0 and pulse index_error
//   undefined -> reads return raw array contents, index_error tied to 0
module rpn_output_queue #(
    parameter int INTEGER_PART_WIDTH    = 11,
    parameter int FRACTIONAL_PART_WIDTH = 8,
    parameter int OUTPUT_QUEUE_SIZE     = 64,
    localparam int NUMBER_WIDTH         = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH,
    localparam int OUTPUT_VALUE_WIDTH   = NUMBER_WIDTH + 1,
    localparam int INDEX_WIDTH          = $clog2(OUTPUT_QUEUE_SIZE),
    localparam int LENGTH_WIDTH         = $clog2(OUTPUT_QUEUE_SIZE + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          push,
    input  logic [OUTPUT_VALUE_WIDTH-1:0] push_data,
    input  logic [INDEX_WIDTH-1:0]        output_queue_index,
    input  logic                          output_queue_get,
    output logic [OUTPUT_VALUE_WIDTH-1:0] output_queue_data_out,
    output logic                          output_queue_ready,
    output logic [LENGTH_WIDTH-1:0]       output_queue_length,
    output logic                          full,
    output logic                          overflow,
    output logic                          index_error
);

    localparam logic [LENGTH_WIDTH-1:0] CAPACITY = LENGTH_WIDTH'(OUTPUT_QUEUE_SIZE);
    localparam logic [LENGTH_WIDTH-1:0] LEN_ONE  = LENGTH_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RESPOND = 1'b1
    } state_t;

    state_t                          state_r;
    state_t                          state_next_s;
    logic [OUTPUT_VALUE_WIDTH-1:0]   mem_r [OUTPUT_QUEUE_SIZE];
    logic [LENGTH_WIDTH-1:0]         length_r;
    logic                            overflow_r;
    logic [OUTPUT_VALUE_WIDTH-1:0]   data_out_r;
    logic                            index_error_r;
    logic                            full_s;
    logic                            push_ok_s;
    logic                            overflow_set_s;
    logic [INDEX_WIDTH-1:0]          write_addr_s;

    assign full_s                = (length_r == CAPACITY);
    assign full                  = full_s;
    assign output_queue_length   = length_r;
    assign overflow              = overflow_r;
    assign output_queue_data_out = data_out_r;
    assign output_queue_ready    = (state_r == ST_RESPOND);
    assign index_error           = index_error_r;

    // Decode push qualification: clear wins over push, full blocks the write
    always_comb begin
        push_ok_s      = 1'b0;
        overflow_set_s = 1'b0;
        write_addr_s   = length_r[INDEX_WIDTH-1:0];
        if (clear) begin
            push_ok_s      = 1'b0;
            overflow_set_s = 1'b0;
        end else if (push) begin
            push_ok_s      = ~full_s;
            overflow_set_s = full_s;
        end else begin
            push_ok_s      = 1'b0;
            overflow_set_s = 1'b0;
        end
    end

    // Read controller next state: stay in RESPOND while gets keep arriving
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (output_queue_get) begin
                    state_next_s = ST_RESPOND;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RESPOND: begin
                if (output_queue_get) begin
                    state_next_s = ST_RESPOND;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Read controller state register; reset drops any pending read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Queue length and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            length_r   <= '0;
            overflow_r <= 1'b0;
        end else if (clear) begin
            length_r   <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                length_r <= length_r + LEN_ONE;
            end else begin
                length_r <= length_r;
            end
            if (overflow_set_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Token storage write port; contents are deliberately never reset
    always_ff @(posedge clk) begin
        if (rst_n && push_ok_s) begin
            mem_r[write_addr_s] <= push_data;
        end
    end

    // Registered read port; old contents are returned on a same-cycle write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out_r    <= '0;
            index_error_r <= 1'b0;
        end else if (output_queue_get) begin
`ifdef OUTPUT_QUEUE_BOUNDS_CHECK_EN
            if (LENGTH_WIDTH'(output_queue_index) >= length_r) begin
                data_out_r    <= '0;
                index_error_r <= 1'b1;
            end else begin
                data_out_r    <= mem_r[output_queue_index];
                index_error_r <= 1'b0;
            end
`else
            data_out_r    <= mem_r[output_queue_index];
            index_error_r <= 1'b0;
`endif
        end else begin
            data_out_r    <= data_out_r;
            index_error_r <= 1'b0;
        end
    end

endmodule

// File: doc/rpn_output_queue.md
RPN_OUTPUT_QUEUE -- requirements
Module: rpn_output_queue

Interface
REQ-001 SHALL have parameter INTEGER_PART_WIDTH, default 11, meaning integer bits of a fixed-point number.
REQ-002 SHALL have parameter FRACTIONAL_PART_WIDTH, default 8, meaning fraction bits of a fixed-point number.
REQ-003 SHALL have parameter OUTPUT_QUEUE_SIZE, default 64, meaning token capacity (power of two, >=2).
REQ-004 SHALL derive NUMBER_WIDTH = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH and OUTPUT_VALUE_WIDTH = NUMBER_WIDTH + 1; token bit [NUMBER_WIDTH] set means operator, clear means number.
REQ-005 SHALL use one clock; reset is synchronous and active-low: clk input 1 system clock, all state on rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 clear  input  1  empty the queue (length to 0, overflow to 0).
REQ-008 push  input  1  append push_data at position length.
REQ-009 push_data  input  OUTPUT_VALUE_WIDTH  token to append.
REQ-010 output_queue_index  input  $clog2(OUTPUT_QUEUE_SIZE)  token position to read.
REQ-011 output_queue_get  input  1  read request for output_queue_index.
REQ-012 output_queue_data_out  output  OUTPUT_VALUE_WIDTH  registered read data.
REQ-013 output_queue_ready  output  1  one-cycle pulse, data_out valid.
REQ-014 output_queue_length  output  $clog2(OUTPUT_QUEUE_SIZE+1)  stored token count.
REQ-015 full  output  1  combinational, length == OUTPUT_QUEUE_SIZE.
REQ-016 overflow  output  1  sticky, push attempted while full.
REQ-017 index_error  output  1  one-cycle pulse with ready, read was out of range (macro only).

Function
REQ-018 Storage SHALL be a synchronous-read array of OUTPUT_QUEUE_SIZE x OUTPUT_VALUE_WIDTH; contents not reset.
REQ-019 push with !full SHALL write push_data at address length and increment length in the same edge.
REQ-020 push with full SHALL not write, hold length, set overflow until clear or reset.
REQ-021 clear SHALL take priority over push in the same cycle; the push is dropped, overflow not set.
REQ-022 get sampled at edge N SHALL produce ready=1 and data_out at edge N+1; fixed latency 1, no stall.
REQ-023 get accepted every cycle back-to-back; each yields exactly one ready pulse one cycle later.
REQ-024 ready SHALL be 0 in any cycle not following a get; data_out SHALL hold its last value when ready=0.
REQ-025 get and push in same cycle: read returns array contents before the write (read-before-write).
REQ-026 get with clear in same cycle: read completes normally with pre-clear array contents.
REQ-027 Length SHALL never exceed OUTPUT_QUEUE_SIZE nor wrap below 0.
REQ-028 Two-state controller: IDLE (no read pending) and RESPOND (ready asserted); IDLE->RESPOND on get, RESPOND->RESPOND on get, RESPOND->IDLE otherwise.

Reset
REQ-029 rst_n=0 at an edge SHALL set length=0, overflow=0, ready=0, index_error=0, data_out=0, state IDLE.
REQ-030 Reset during a pending read SHALL suppress that read's ready pulse; reset overrides clear, push, get.

Configuration
REQ-031 Macro OUTPUT_QUEUE_BOUNDS_CHECK_EN defined: get with index >= length SHALL return data_out=0 with ready=1 and index_error=1.
REQ-032 Macro undefined: no range check, data_out = raw array contents at index, index_error tied 0.

Verification
REQ-033 Reset; push 512, 1280, {1,19'd1}; get index 1 -> next cycle ready=1, data_out=1280, length=3.
REQ-034 Gets on indices 0,1,2 in consecutive cycles -> ready high 3 cycles, data 512, 1280, 0x80001.
REQ-035 Push 65 tokens -> full=1 after 64th, length=64, overflow=1 after 65th; clear -> length=0, overflow=0, full=0.
REQ-036 Length 3, get index 3 -> with macro data_out=0, index_error=1; without macro index_error=0.
REQ-037 Get then rst_n=0 on following edge -> no ready pulse, length=0, data_out=0.
REQ-038 Length 2, push 7 and get index 2 same cycle -> read returns pre-write contents (macro: error, data 0); then get index 2 -> 7.
